// File: rtl/riscv_alu_issue.sv
// ID/EX issue stage ahead of riscv_alu. It resolves rs1/rs2 through MEM/WB forwarding,
// selects the ALU operands, stalls on load-use hazards and registers the result into EX.
module riscv_alu_issue #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  output logic            o_id_ready,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [RA_W-1:0] i_id_rs1_addr,
  input  logic [RA_W-1:0] i_id_rs2_addr,
  input  logic [XLEN-1:0] i_id_rs1_data,
  input  logic [XLEN-1:0] i_id_rs2_data,
  input  logic            i_id_use_rs1,
  input  logic            i_id_use_rs2,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic [1:0]      i_id_src_a,
  input  logic [1:0]      i_id_src_b,
  input  logic [4:0]      i_id_alu_ctrl,
  input  logic [RA_W-1:0] i_id_rd_addr,
  input  logic            i_id_rd_we,
  input  logic            i_mem_fwd_we,
  input  logic            i_mem_fwd_is_load,
  input  logic [RA_W-1:0] i_mem_fwd_addr,
  input  logic [XLEN-1:0] i_mem_fwd_data,
  input  logic            i_wb_fwd_we,
  input  logic [RA_W-1:0] i_wb_fwd_addr,
  input  logic [XLEN-1:0] i_wb_fwd_data,
  input  logic            i_flush,
  input  logic            i_ex_ready,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [4:0]      o_alu_ctrl,
  output logic [XLEN-1:0] o_ex_rs2_data,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [RA_W-1:0] o_ex_rd_addr,
  output logic            o_ex_rd_we
);

  localparam logic [XLEN-1:0] CONST_FOUR = {{(XLEN-3){1'b0}}, 3'b100};

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hazard;
  logic            advance;
  logic            capture;

  // NOTE: combinational blocks use blocking '=' and assign a default first so no latch is inferred.
  always_comb begin
    rs1_fwd = i_id_rs1_data;
    if (i_id_rs1_addr == '0)
      rs1_fwd = '0;
    else if (i_mem_fwd_we && (i_mem_fwd_addr == i_id_rs1_addr))
      rs1_fwd = i_mem_fwd_data;
    else if (i_wb_fwd_we && (i_wb_fwd_addr == i_id_rs1_addr))
      rs1_fwd = i_wb_fwd_data;

    rs2_fwd = i_id_rs2_data;
    if (i_id_rs2_addr == '0)
      rs2_fwd = '0;
    else if (i_mem_fwd_we && (i_mem_fwd_addr == i_id_rs2_addr))
      rs2_fwd = i_mem_fwd_data;
    else if (i_wb_fwd_we && (i_wb_fwd_addr == i_id_rs2_addr))
      rs2_fwd = i_wb_fwd_data;
  end

  always_comb begin
    op_a = '0;
    case (i_id_src_a)
      2'b00:   op_a = rs1_fwd;
      2'b01:   op_a = i_id_pc;
      default: op_a = '0;
    endcase

    op_b = '0;
    case (i_id_src_b)
      2'b00:   op_b = rs2_fwd;
      2'b01:   op_b = i_id_imm;
      2'b10:   op_b = CONST_FOUR;
      default: op_b = '0;
    endcase
  end

  // A load in MEM has no data yet; wait one cycle and pick it up from WB.
  assign hazard = i_mem_fwd_is_load && i_mem_fwd_we && (i_mem_fwd_addr != '0) &&
                  ((i_id_use_rs1 && (i_mem_fwd_addr == i_id_rs1_addr)) ||
                   (i_id_use_rs2 && (i_mem_fwd_addr == i_id_rs2_addr)));

  assign advance    = !o_ex_valid || i_ex_ready;
  assign o_id_ready = advance && !hazard && !i_flush;
  assign capture    = i_id_valid && o_id_ready;

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ex_valid    <= 1'b0;
      o_alu_a       <= '0;
      o_alu_b       <= '0;
      o_alu_ctrl    <= '0;
      o_ex_rs2_data <= '0;
      o_ex_pc       <= '0;
      o_ex_rd_addr  <= '0;
      o_ex_rd_we    <= 1'b0;
    end else if (i_flush) begin
      o_ex_valid <= 1'b0;
      o_ex_rd_we <= 1'b0;
    end else if (capture) begin
      o_ex_valid    <= 1'b1;
      o_alu_a       <= op_a;
      o_alu_b       <= op_b;
      o_alu_ctrl    <= i_id_alu_ctrl;
      o_ex_rs2_data <= rs2_fwd;
      o_ex_pc       <= i_id_pc;
      o_ex_rd_addr  <= i_id_rd_addr;
      o_ex_rd_we    <= i_id_rd_we;
    end else if (advance) begin
      o_ex_valid <= 1'b0;
      o_ex_rd_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_alu_issue.sv
// Self-checking bench for riscv_alu_issue: directed vector table, hand-written stall/flush/reset
// sequences, then randomized traffic against a cycle-level reference model.
module tb_riscv_alu_issue;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam logic [4:0] ALU_CTRL_ADD = 5'd0;
  localparam logic [4:0] ALU_CTRL_SUB = 5'd1;

  typedef struct {
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        use_rs1, use_rs2;
    logic [31:0] imm, pc;
    logic [1:0]  src_a, src_b;
    logic [4:0]  ctrl, rd;
    logic        rd_we;
    logic        mem_we, mem_load;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] exp_a, exp_b, exp_rs2;
  } vec_t;

  logic            i_clk, i_rst, i_id_valid, o_id_ready;
  logic [XLEN-1:0] i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm;
  logic [RA_W-1:0] i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
  logic            i_id_use_rs1, i_id_use_rs2, i_id_rd_we;
  logic [1:0]      i_id_src_a, i_id_src_b;
  logic [4:0]      i_id_alu_ctrl;
  logic            i_mem_fwd_we, i_mem_fwd_is_load, i_wb_fwd_we;
  logic [RA_W-1:0] i_mem_fwd_addr, i_wb_fwd_addr;
  logic [XLEN-1:0] i_mem_fwd_data, i_wb_fwd_data;
  logic            i_flush, i_ex_ready, o_ex_valid, o_ex_rd_we;
  logic [XLEN-1:0] o_alu_a, o_alu_b, o_ex_rs2_data, o_ex_pc;
  logic [4:0]      o_alu_ctrl;
  logic [RA_W-1:0] o_ex_rd_addr;

  int n_cmp  = 0;
  int n_fail = 0;

  riscv_alu_issue #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_id_pc(i_id_pc), .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2), .i_id_imm(i_id_imm),
    .i_id_src_a(i_id_src_a), .i_id_src_b(i_id_src_b), .i_id_alu_ctrl(i_id_alu_ctrl),
    .i_id_rd_addr(i_id_rd_addr), .i_id_rd_we(i_id_rd_we),
    .i_mem_fwd_we(i_mem_fwd_we), .i_mem_fwd_is_load(i_mem_fwd_is_load),
    .i_mem_fwd_addr(i_mem_fwd_addr), .i_mem_fwd_data(i_mem_fwd_data),
    .i_wb_fwd_we(i_wb_fwd_we), .i_wb_fwd_addr(i_wb_fwd_addr), .i_wb_fwd_data(i_wb_fwd_data),
    .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_ex_valid(o_ex_valid),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_ctrl(o_alu_ctrl),
    .o_ex_rs2_data(o_ex_rs2_data), .o_ex_pc(o_ex_pc), .o_ex_rd_addr(o_ex_rd_addr),
    .o_ex_rd_we(o_ex_rd_we)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    i_id_rs1_addr = v.rs1_addr;  i_id_rs2_addr = v.rs2_addr;
    i_id_rs1_data = v.rs1_data;  i_id_rs2_data = v.rs2_data;
    i_id_use_rs1 = v.use_rs1;    i_id_use_rs2 = v.use_rs2;
    i_id_imm = v.imm;            i_id_pc = v.pc;
    i_id_src_a = v.src_a;        i_id_src_b = v.src_b;
    i_id_alu_ctrl = v.ctrl;      i_id_rd_addr = v.rd;  i_id_rd_we = v.rd_we;
    i_mem_fwd_we = v.mem_we;     i_mem_fwd_is_load = v.mem_load;
    i_mem_fwd_addr = v.mem_addr; i_mem_fwd_data = v.mem_data;
    i_wb_fwd_we = v.wb_we;       i_wb_fwd_addr = v.wb_addr;  i_wb_fwd_data = v.wb_data;
  endtask

  task automatic check_ex(input string tag, input vec_t v);
    check({tag, ".valid"}, 32'(o_ex_valid), 32'd1);
    check({tag, ".a"}, o_alu_a, v.exp_a);
    check({tag, ".b"}, o_alu_b, v.exp_b);
    check({tag, ".ctrl"}, 32'(o_alu_ctrl), 32'(v.ctrl));
    check({tag, ".rs2"}, o_ex_rs2_data, v.exp_rs2);
    check({tag, ".pc"}, o_ex_pc, v.pc);
    check({tag, ".rd"}, 32'(o_ex_rd_addr), 32'(v.rd));
    check({tag, ".rd_we"}, 32'(o_ex_rd_we), 32'(v.rd_we));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 32'(o_ex_valid), 32'd0);
    check({tag, ".a"}, o_alu_a, 32'd0);
    check({tag, ".b"}, o_alu_b, 32'd0);
    check({tag, ".ctrl"}, 32'(o_alu_ctrl), 32'd0);
    check({tag, ".rs2"}, o_ex_rs2_data, 32'd0);
    check({tag, ".pc"}, o_ex_pc, 32'd0);
    check({tag, ".rd"}, 32'(o_ex_rd_addr), 32'd0);
    check({tag, ".rd_we"}, 32'(o_ex_rd_we), 32'd0);
  endtask

  // Reference: value a source register resolves to, by the forwarding priority rules.
  function automatic logic [31:0] ref_src(input logic [4:0] rs, input logic [31:0] rf, input vec_t v);
    if (rs == 0) return 32'd0;
    if (v.mem_we && v.mem_addr == rs) return v.mem_data;
    if (v.wb_we && v.wb_addr == rs) return v.wb_data;
    return rf;
  endfunction

  vec_t vecs[9];
  vec_t v, hz;

  // Reference model state for the random phase.
  logic        m_valid, m_rd_we;
  logic [31:0] m_a, m_b, m_rs2, m_pc;
  logic [4:0]  m_ctrl, m_rd;

  initial begin
    // Directed vectors with hand-derived expectations.
    v = blank(); v.rs1_addr = 1; v.rs1_data = 5; v.rs2_addr = 2; v.rs2_data = 7;
    v.use_rs1 = 1; v.use_rs2 = 1; v.ctrl = ALU_CTRL_ADD; v.rd = 3; v.rd_we = 1; v.pc = 32'h10;
    v.exp_a = 5; v.exp_b = 7; v.exp_rs2 = 7; vecs[0] = v;

    v = blank(); v.rs1_addr = 1; v.rs1_data = 32'h11; v.rs2_addr = 2; v.rs2_data = 9;
    v.mem_we = 1; v.mem_addr = 1; v.mem_data = 32'h100; v.wb_we = 1; v.wb_addr = 1; v.wb_data = 32'h200;
    v.ctrl = ALU_CTRL_ADD; v.rd = 5; v.rd_we = 1; v.pc = 32'h14;
    v.exp_a = 32'h100; v.exp_b = 9; v.exp_rs2 = 9; vecs[1] = v;

    v = blank(); v.rs1_addr = 0; v.rs1_data = 32'hDEAD; v.rs2_addr = 2; v.rs2_data = 9;
    v.mem_we = 1; v.mem_addr = 0; v.mem_data = 32'h100; v.wb_we = 1; v.wb_addr = 0; v.wb_data = 32'h200;
    v.rd = 6; v.rd_we = 1; v.pc = 32'h18;
    v.exp_a = 0; v.exp_b = 9; v.exp_rs2 = 9; vecs[2] = v;

    v = blank(); v.rs1_addr = 4; v.rs1_data = 32'h44; v.rs2_addr = 2; v.rs2_data = 1;
    v.wb_we = 1; v.wb_addr = 2; v.wb_data = 32'h300; v.mem_we = 1; v.mem_addr = 7; v.mem_data = 32'h777;
    v.ctrl = ALU_CTRL_SUB; v.rd = 7; v.rd_we = 1; v.pc = 32'h1C;
    v.exp_a = 32'h44; v.exp_b = 32'h300; v.exp_rs2 = 32'h300; vecs[3] = v;

    v = blank(); v.src_a = 2'b01; v.pc = 32'h80; v.src_b = 2'b10; v.rs1_addr = 1; v.rs1_data = 5;
    v.rs2_addr = 2; v.rs2_data = 7; v.ctrl = 5'd3; v.rd = 1; v.rd_we = 1;
    v.exp_a = 32'h80; v.exp_b = 4; v.exp_rs2 = 7; vecs[4] = v;

    v = blank(); v.src_a = 2'b10; v.src_b = 2'b01; v.imm = 32'hFFFF_FFF0; v.rs1_addr = 1; v.rs1_data = 5;
    v.rs2_addr = 2; v.rs2_data = 7; v.ctrl = 5'd9; v.pc = 32'h84;
    v.exp_a = 0; v.exp_b = 32'hFFFF_FFF0; v.exp_rs2 = 7; vecs[5] = v;

    v = blank(); v.src_a = 2'b11; v.src_b = 2'b11; v.rs1_addr = 1; v.rs1_data = 5; v.rs2_addr = 5;
    v.rs2_data = 1; v.mem_we = 1; v.mem_addr = 5; v.mem_data = 32'hAA; v.rd = 9; v.rd_we = 1; v.pc = 32'h88;
    v.exp_a = 0; v.exp_b = 0; v.exp_rs2 = 32'hAA; vecs[6] = v;

    v = blank(); v.rs1_addr = 6; v.rs1_data = 32'h60; v.mem_we = 0; v.mem_addr = 6; v.mem_data = 32'hBAD;
    v.wb_we = 1; v.wb_addr = 6; v.wb_data = 32'h66; v.rs2_addr = 0; v.rs2_data = 32'h1234;
    v.ctrl = 5'd17; v.rd = 31; v.rd_we = 1; v.pc = 32'h8C;
    v.exp_a = 32'h66; v.exp_b = 0; v.exp_rs2 = 0; vecs[7] = v;

    v = blank(); v.rs2_addr = 3; v.rs2_data = 32'h33; v.use_rs2 = 0; v.mem_we = 1; v.mem_load = 1;
    v.mem_addr = 3; v.mem_data = 32'h3000; v.rd = 2; v.rd_we = 1; v.pc = 32'h90;
    v.exp_a = 0; v.exp_b = 32'h3000; v.exp_rs2 = 32'h3000; vecs[8] = v;

    // Reset state
    apply(blank());
    i_rst = 1'b1; i_id_valid = 1'b0; i_flush = 1'b0; i_ex_ready = 1'b1;
    #3;
    check_zero("reset");
    @(negedge i_clk) i_rst = 1'b0;
    tick();
    check("idle.valid", 32'(o_ex_valid), 32'd0);

    // Table: back-to-back captures with EX always ready
    foreach (vecs[i]) begin
      apply(vecs[i]);
      i_id_valid = 1'b1;
      #1;
      check($sformatf("vec%0d.ready", i), 32'(o_id_ready), 32'd1);
      tick();
      check_ex($sformatf("vec%0d", i), vecs[i]);
    end

    // Load-use: bubble, then capture with the load data coming from WB
    hz = blank(); hz.rs1_addr = 1; hz.rs1_data = 32'h10; hz.use_rs1 = 1; hz.rs2_addr = 3;
    hz.rs2_data = 32'h999; hz.use_rs2 = 1; hz.ctrl = ALU_CTRL_SUB; hz.rd = 4; hz.rd_we = 1; hz.pc = 32'h40;
    hz.mem_we = 1; hz.mem_load = 1; hz.mem_addr = 3; hz.mem_data = 32'hBEEF;
    apply(hz);
    #1;
    check("hazard.ready", 32'(o_id_ready), 32'd0);
    tick();
    check("hazard.bubble", 32'(o_ex_valid), 32'd0);
    check("hazard.bubble_we", 32'(o_ex_rd_we), 32'd0);
    hz.mem_we = 0; hz.mem_load = 0; hz.wb_we = 1; hz.wb_addr = 3; hz.wb_data = 32'h55;
    hz.exp_a = 32'h10; hz.exp_b = 32'h55; hz.exp_rs2 = 32'h55;
    apply(hz);
    #1;
    check("hazard.ready2", 32'(o_id_ready), 32'd1);
    tick();
    check_ex("hazard.cap", hz);

    // Hold for 3 cycles; forwarding changes must not disturb the held instruction
    i_ex_ready = 1'b0;
    apply(vecs[0]);
    for (int k = 0; k < 3; k++) begin
      i_wb_fwd_we = 1'b1; i_wb_fwd_addr = 5'd1; i_wb_fwd_data = 32'hC0DE_0000 + 32'(k);
      #1;
      check($sformatf("hold%0d.ready", k), 32'(o_id_ready), 32'd0);
      tick();
      check_ex($sformatf("hold%0d", k), hz);
    end
    apply(vecs[0]);
    i_ex_ready = 1'b1;
    #1;
    check("release.ready", 32'(o_id_ready), 32'd1);
    tick();
    check_ex("release", vecs[0]);

    // Flush of a held instruction while another is offered
    i_ex_ready = 1'b0; i_flush = 1'b1;
    apply(vecs[4]);
    #1;
    check("flush.ready", 32'(o_id_ready), 32'd0);
    tick();
    check("flush.valid", 32'(o_ex_valid), 32'd0);
    check("flush.rd_we", 32'(o_ex_rd_we), 32'd0);
    i_flush = 1'b0; i_id_valid = 1'b0; i_ex_ready = 1'b1;
    tick();
    check("flush.dropped", 32'(o_ex_valid), 32'd0);

    // Asynchronous reset in the middle of a hold
    apply(vecs[6]);
    i_id_valid = 1'b1;
    tick();
    check_ex("prerst", vecs[6]);
    i_id_valid = 1'b0; i_ex_ready = 1'b0;
    tick();
    check("prerst.held", 32'(o_ex_valid), 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check_zero("async_rst");
    #2 i_rst = 1'b0;
    i_ex_ready = 1'b1;
    tick();
    check("postrst.valid", 32'(o_ex_valid), 32'd0);

    // Random traffic against the reference model
    m_valid = 0; m_rd_we = 0; m_a = 0; m_b = 0; m_rs2 = 0; m_pc = 0; m_ctrl = 0; m_rd = 0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra, rb, r2;
      logic hzd, rdy, cap;
      v = blank();
      v.rs1_addr = 5'($urandom_range(0, 3)); v.rs2_addr = 5'($urandom_range(0, 3));
      v.rs1_data = $urandom; v.rs2_data = $urandom;
      v.use_rs1 = 1'($urandom); v.use_rs2 = 1'($urandom);
      v.imm = $urandom; v.pc = $urandom;
      v.src_a = 2'($urandom); v.src_b = 2'($urandom);
      v.ctrl = 5'($urandom); v.rd = 5'($urandom); v.rd_we = 1'($urandom);
      v.mem_we = 1'($urandom); v.mem_load = ($urandom_range(0, 2) == 0);
      v.mem_addr = 5'($urandom_range(0, 3)); v.mem_data = $urandom;
      v.wb_we = 1'($urandom); v.wb_addr = 5'($urandom_range(0, 3)); v.wb_data = $urandom;
      apply(v);
      i_id_valid = ($urandom_range(0, 3) != 0);
      i_ex_ready = ($urandom_range(0, 3) != 0);
      i_flush    = ($urandom_range(0, 7) == 0);
      #1;

      ra = (v.src_a == 2'd0) ? ref_src(v.rs1_addr, v.rs1_data, v) :
           (v.src_a == 2'd1) ? v.pc : 32'd0;
      r2 = ref_src(v.rs2_addr, v.rs2_data, v);
      case (v.src_b)
        2'd0: rb = r2;
        2'd1: rb = v.imm;
        2'd2: rb = 32'd4;
        default: rb = 32'd0;
      endcase
      hzd = v.mem_load && v.mem_we && v.mem_addr != 0 &&
            ((v.use_rs1 && v.mem_addr == v.rs1_addr) || (v.use_rs2 && v.mem_addr == v.rs2_addr));
      rdy = (!m_valid || i_ex_ready) && !hzd && !i_flush;
      check($sformatf("rnd%0d.ready", n), 32'(o_id_ready), 32'(rdy));
      cap = i_id_valid && rdy;

      if (i_flush) begin
        m_valid = 0; m_rd_we = 0;
      end else if (cap) begin
        m_valid = 1; m_a = ra; m_b = rb; m_rs2 = r2; m_pc = v.pc;
        m_ctrl = v.ctrl; m_rd = v.rd; m_rd_we = v.rd_we;
      end else if (!m_valid || i_ex_ready) begin
        m_valid = 0; m_rd_we = 0;
      end

      tick();
      check($sformatf("rnd%0d.valid", n), 32'(o_ex_valid), 32'(m_valid));
      check($sformatf("rnd%0d.rd_we", n), 32'(o_ex_rd_we), 32'(m_rd_we));
      if (m_valid) begin
        check($sformatf("rnd%0d.a", n), o_alu_a, m_a);
        check($sformatf("rnd%0d.b", n), o_alu_b, m_b);
        check($sformatf("rnd%0d.ctrl", n), 32'(o_alu_ctrl), 32'(m_ctrl));
        check($sformatf("rnd%0d.rs2", n), o_ex_rs2_data, m_rs2);
        check($sformatf("rnd%0d.pc", n), o_ex_pc, m_pc);
        check($sformatf("rnd%0d.rd", n), 32'(o_ex_rd_addr), 32'(m_rd));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_alu_issue.md
Name: riscv_alu_issue

Overview:
ID/EX pipeline stage directly upstream of riscv_alu in the RV32I core. It captures decoded instructions and resolves rs1/rs2 operands through MEM- and WB-stage forwarding. It selects ALU operand sources, detects load-use hazards and inserts bubbles. Its registered outputs drive the ALU inputs (a, b, ctrl) and carry rd and store-data information into EX.

Parameters:
XLEN, 32, datapath width; must match the ALU's XLEN.
RA_W, 5, register address width.

Ports:
i_clk  in  1  core clock; all state updates on the rising edge.
i_rst  in  1  reset, asynchronous, active-high.
i_id_valid  in  1  decode presents an instruction.
o_id_ready  out  1  stage accepts the instruction this cycle.
i_id_pc  in  XLEN  instruction PC.
i_id_rs1_addr, i_id_rs2_addr  in  RA_W  source register indices.
i_id_rs1_data, i_id_rs2_data  in  XLEN  register-file read data.
i_id_use_rs1, i_id_use_rs2  in  1  instruction actually reads rs1 / rs2.
i_id_imm  in  XLEN  sign-extended immediate.
i_id_src_a  in  2  operand A select: 00 rs1, 01 pc, 10 zero, 11 zero.
i_id_src_b  in  2  operand B select: 00 rs2, 01 imm, 10 constant 4, 11 zero.
i_id_alu_ctrl  in  5  ALU_CTRL_* code.
i_id_rd_addr  in  RA_W  destination register.
i_id_rd_we  in  1  writes rd.
i_mem_fwd_we, i_mem_fwd_is_load  in  1  MEM-stage instruction writes rd / is a load.
i_mem_fwd_addr  in  RA_W  MEM-stage rd.
i_mem_fwd_data  in  XLEN  MEM-stage ALU result.
i_wb_fwd_we  in  1  WB-stage writes rd.
i_wb_fwd_addr  in  RA_W  WB-stage rd.
i_wb_fwd_data  in  XLEN  WB-stage write data.
i_flush  in  1  kill the instruction held and the one being offered.
i_ex_ready  in  1  EX consumes the held instruction.
o_ex_valid  out  1  held instruction is valid.
o_alu_a, o_alu_b  out  XLEN  ALU operands.
o_alu_ctrl  out  5  ALU control.
o_ex_rs2_data  out  XLEN  forwarded rs2 value, used for stores.
o_ex_pc  out  XLEN  PC of the held instruction.
o_ex_rd_addr  out  RA_W  destination register.
o_ex_rd_we  out  1  destination write enable, qualified by o_ex_valid.

Behaviour:
- Reset, asynchronous, any time, including mid-stall: every registered output is 0 (o_ex_valid=0, o_alu_a/b=0, o_alu_ctrl=0, o_ex_rd_we=0, etc.). No instruction survives reset.
- Forwarding per source, combinational in ID. Priority order:
  - MEM: if mem_we and mem_addr==rs and rs!=0, use MEM data.
  - WB: otherwise, if wb_we and wb_addr==rs and rs!=0, use WB data.
  - Otherwise use the register-file data.
  - rs==0 always yields 0, regardless of register-file data.
- Load-use hazard: i_mem_fwd_is_load & i_mem_fwd_we & mem_addr!=0 & ((use_rs1 & mem_addr==rs1) | (use_rs2 & mem_addr==rs2)).
- o_id_ready = (!o_ex_valid | i_ex_ready) & !hazard & !i_flush. Combinational.
- Capture on i_id_valid & o_id_ready:
  - Next edge loads the selected operands, ctrl, rd, we, pc and forwarded rs2.
  - Sets o_ex_valid=1.
  - Latency is 1 cycle, ID to EX.
- Bubble: if (!o_ex_valid | i_ex_ready) and there is no capture, o_ex_valid<=0 and o_ex_rd_we<=0. Data registers may hold stale values.
- Hold: o_ex_valid & !i_ex_ready and no flush keeps all outputs stable. Forwarding is not re-evaluated for the held instruction.
- Flush: next edge sets o_ex_valid<=0 and o_ex_rd_we<=0. Flush has priority over capture and hold. The instruction offered in that cycle is dropped (ready=0).
- Hazard with downstream free: a bubble is inserted. The instruction stays offered and is captured the following cycle, when the load result is available from WB.
- Operand arithmetic is pure selection. Constant 4 is zero-extended to XLEN. No other arithmetic is performed in this stage.

Test Plan:
1. Reset, then offer ADD, rs1=x1 (data 5), rs2=x2 (data 7), src 00/00, no forwarding -> one cycle later o_ex_valid=1, o_alu_a=5, o_alu_b=7, o_alu_ctrl=ALU_CTRL_ADD, rd_we=1.
2. MEM fwd x1=0x100 and WB fwd x1=0x200, rs1=x1 -> o_alu_a=0x100. Same case with rs1=x0, rf data 0xDEAD -> o_alu_a=0.
3. MEM load to x3 with use_rs2, rs2=x3 -> o_id_ready=0 for one cycle and a bubble (o_ex_valid=0). Next cycle, with WB fwd x3=0x55, the instruction is captured with o_alu_b=0x55.
4. i_ex_ready=0 for 3 cycles while valid -> outputs frozen and o_id_ready=0. Ready restored -> the next instruction is captured on that edge.
5. i_flush with a held instruction and i_id_valid=1 -> next cycle o_ex_valid=0 and the offered instruction is not captured. i_rst asserted mid-hold -> all outputs 0 immediately, without a clock edge.
6. src_a=01, pc=0x80, src_b=10 -> o_alu_a=0x80, o_alu_b=4. src_b=01, imm=0xFFFFFFF0 -> o_alu_b=0xFFFFFFF0.
